// File: rtl/y86_mem_responder_if.sv
// CPU bus and program-loader byte stream between the y86 CPU/bench and the memory responder.
interface y86_mem_responder_if #(parameter int AW = 10);
  logic [31:0]   bus_A;
  logic          bus_RE;
  logic          bus_WE;
  logic [31:0]   bus_wdata;
  logic [31:0]   bus_rdata;
  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  logic          ld_last;

  modport master (
    output bus_A, bus_RE, bus_WE, bus_wdata, ld_valid, ld_addr, ld_data, ld_last,
    input  bus_rdata, ld_ready
  );
  modport slave (
    input  bus_A, bus_RE, bus_WE, bus_wdata, ld_valid, ld_addr, ld_data, ld_last,
    output bus_rdata, ld_ready
  );
endinterface

// File: rtl/y86_mem_responder.sv
// Byte-addressable little-endian memory for the y86_seq CPU: loader-filled, zero-latency
// unaligned 32-bit reads, word stores, saturating access counters and a sticky range error.
module y86_mem_responder #(
  parameter int AW = 10,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  y86_mem_responder_if.slave bus,
  output logic            cpu_rst,
  output logic [CW-1:0]   rd_count,
  output logic [CW-1:0]   wr_count,
  output logic            addr_err
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {LOAD, START, RUN} state_t;
  state_t state_q, state_d;

  logic [7:0]    mem [0:DEPTH-1];
  logic          ld_rdy, ld_fire, run;
  logic [32:0]   a_end;
  logic          in_range, rd_ok, wr_ok, bad;
  logic [AW-1:0] a0, a1, a2, a3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // START holds the CPU in reset one extra cycle so it wakes after the last byte is written.
  always_comb begin
    state_d = state_q;
    cpu_rst = 1'b1;
    ld_rdy  = 1'b0;
    case (state_q)
      LOAD: begin
        ld_rdy = 1'b1;
        if (bus.ld_valid && bus.ld_last) state_d = START;
      end
      START:   state_d = RUN;
      RUN:     cpu_rst = 1'b0;
      default: state_d = LOAD;
    endcase
  end

  assign bus.ld_ready = ld_rdy;
  assign ld_fire      = bus.ld_valid & ld_rdy;
  assign run          = (state_q == RUN);

  // 33-bit sum rejects both high address bits and a word straddling the top of memory.
  assign a_end    = {1'b0, bus.bus_A} + 33'd3;
  assign in_range = a_end < 33'(DEPTH);
  assign rd_ok    = run & bus.bus_RE & in_range;
  assign wr_ok    = run & bus.bus_WE & in_range;
  assign bad      = run & (bus.bus_RE | bus.bus_WE) & ~in_range;

  assign a0 = bus.bus_A[AW-1:0];
  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);

  assign bus.bus_rdata = rd_ok ? {mem[a3], mem[a2], mem[a1], mem[a0]} : 32'd0;

  always_ff @(posedge clk) begin
    if (ld_fire) begin
      mem[bus.ld_addr] <= bus.ld_data;
    end else if (wr_ok) begin
      mem[a0] <= bus.bus_wdata[7:0];
      mem[a1] <= bus.bus_wdata[15:8];
      mem[a2] <= bus.bus_wdata[23:16];
      mem[a3] <= bus.bus_wdata[31:24];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
      addr_err <= 1'b0;
    end else begin
      if (rd_ok && rd_count != '1) rd_count <= rd_count + CW'(1);
      if (wr_ok && wr_count != '1) wr_count <= wr_count + CW'(1);
      if (bad) addr_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_y86_mem_responder.sv
// Randomized scoreboard bench for y86_mem_responder against a byte-array reference memory.
module tb_y86_mem_responder;
  localparam int AW = 10;
  localparam int CW = 4;
  localparam int DEPTH = 1 << AW;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  y86_mem_responder_if #(.AW(AW)) bus ();
  logic          cpu_rst;
  logic [CW-1:0] rd_count, wr_count;
  logic          addr_err;

  y86_mem_responder #(.AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .cpu_rst(cpu_rst), .rd_count(rd_count), .wr_count(wr_count), .addr_err(addr_err)
  );

  logic [7:0]  ref_mem [DEPTH];
  logic [31:0] exp_q [$];
  int  m_rd, m_wr;
  bit  m_err, running;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the bus is reading, the DUT presents a word to compare.
  always @(negedge clk) begin
    if (bus.bus_RE === 1'b1) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rdata_unexpected actual=%h expected=none", bus.bus_rdata);
      end else begin
        chk("rdata", bus.bus_rdata, exp_q.pop_front());
      end
    end
  end

  function automatic bit addr_ok(logic [31:0] a);
    return (longint'(a) + 3) < DEPTH;
  endfunction

  task automatic check_status(string tag);
    chk({tag, "_rd_count"}, 32'(rd_count), 32'(m_rd));
    chk({tag, "_wr_count"}, 32'(wr_count), 32'(m_wr));
    chk({tag, "_addr_err"}, 32'(addr_err), 32'(m_err));
    chk({tag, "_cpu_rst"},  32'(cpu_rst),  32'(!running));
  endtask

  // One bus cycle; called at posedge+1, returns at the next posedge+1.
  task automatic acc(bit re, bit we, logic [31:0] a, logic [31:0] d);
    bit ok;
    int i;
    ok = addr_ok(a);
    i  = ok ? int'(a) : 0;
    bus.bus_A = a; bus.bus_RE = re; bus.bus_WE = we; bus.bus_wdata = d;
    if (re) exp_q.push_back((running && ok) ?
      {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]} : 32'd0);
    @(posedge clk); #1;
    bus.bus_RE = 1'b0; bus.bus_WE = 1'b0;
    if (running) begin
      if ((re || we) && !ok) m_err = 1'b1;
      if (ok && re && m_rd < SAT) m_rd++;
      if (ok && we) begin
        if (m_wr < SAT) m_wr++;
        for (int k = 0; k < 4; k++) ref_mem[i+k] = d[8*k +: 8];
      end
    end
  endtask

  task automatic load_byte(int a, logic [7:0] d, bit last);
    chk("ld_ready_load", 32'(bus.ld_ready), 32'd1);
    bus.ld_valid = 1'b1; bus.ld_addr = AW'(a); bus.ld_data = d; bus.ld_last = last;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic finish_load();
    chk("start_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("start_ld_ready", 32'(bus.ld_ready), 32'd0);
    @(posedge clk); #1;
    running = 1'b1;
    chk("run_ld_ready", 32'(bus.ld_ready), 32'd0);
    check_status("run_entry");
  endtask

  initial begin
    logic [7:0] b;
    logic [31:0] a;
    bus.bus_A = '0; bus.bus_RE = 1'b0; bus.bus_WE = 1'b0; bus.bus_wdata = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_last = 1'b0;
    m_rd = 0; m_wr = 0; m_err = 1'b0; running = 1'b0;

    #12;
    check_status("reset");
    chk("reset_ld_ready", 32'(bus.ld_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Bus activity before RUN is ignored.
    acc(1'b1, 1'b1, 32'd5, 32'hFFFF_FFFF);
    check_status("preload_bus");

    for (int i = 0; i < DEPTH; i++) begin
      case (i)
        0: b = 8'h30;  1: b = 8'hF0;  2: b = 8'h01;
        5: b = 8'h11;  6: b = 8'h22;  7: b = 8'h33;  8: b = 8'h44;
        32: b = 8'h04; 33: b = 8'h03; 34: b = 8'h02; 35: b = 8'h01;
        default: b = 8'($urandom);
      endcase
      load_byte(i, b, i == DEPTH - 1);
    end
    finish_load();

    // Loader handshake ignored in RUN.
    bus.ld_valid = 1'b1; bus.ld_addr = AW'(5); bus.ld_data = 8'hFF; bus.ld_last = 1'b1;
    @(posedge clk); #1;
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    chk("run_ld_ignored_cpu_rst", 32'(cpu_rst), 32'd0);

    acc(1'b1, 1'b0, 32'd5, 32'd0);
    chk("read5_model", {ref_mem[8], ref_mem[7], ref_mem[6], ref_mem[5]}, 32'h4433_2211);
    check_status("read5");
    acc(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    acc(1'b1, 1'b0, 32'h11, 32'd0);
    acc(1'b1, 1'b0, 32'h13, 32'd0);
    check_status("write10");
    acc(1'b1, 1'b1, 32'h20, 32'hAAAA_AAAA);
    acc(1'b1, 1'b0, 32'h20, 32'd0);
    check_status("rw20");
    acc(1'b1, 1'b0, 32'h3FE, 32'd0);
    acc(1'b0, 1'b1, 32'h8000_0000, 32'h1234_5678);
    check_status("range_err");
    acc(1'b1, 1'b0, 32'h3FC, 32'd0);
    acc(1'b1, 1'b0, 32'h3FD, 32'd0);
    acc(1'b0, 1'b1, 32'h3FD, 32'h5555_5555);
    acc(1'b1, 1'b0, 32'h3FC, 32'd0);
    check_status("top_edge");

    // Random traffic drives both counters into saturation.
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
      acc(1'($urandom), 1'($urandom), a, $urandom);
    end
    check_status("random");

    // Asynchronous reset pulse mid-RUN.
    #2 rst_n = 1'b0;
    #1;
    running = 1'b0; m_rd = 0; m_wr = 0; m_err = 1'b0;
    check_status("async_reset");
    chk("async_reset_ld_ready", 32'(bus.ld_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    load_byte(32'h200, 8'h5A, 1'b1);
    finish_load();

    acc(1'b1, 1'b0, 32'd5, 32'd0);
    acc(1'b1, 1'b0, 32'h1FE, 32'd0);
    for (int n = 0; n < 10; n++) acc(1'b1, 1'b0, 32'($urandom_range(0, DEPTH - 4)), 32'd0);
    check_status("after_reload");

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rdata_pending actual=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
